jt93cxx: RTL and testbench



---
 rtl/jt93cxx_pkg.sv | 26 ++
 rtl/jt93cxx_if.sv | 30 +++
 rtl/jt93cxx_dpram.sv | 29 ++
 rtl/jt93cxx.sv | 228 ++++++++++++++++++++++
 tb/tb_jt93cxx.sv | 301 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/jt93cxx_pkg.sv
// Shared types and command codes for the jt93cxx Microwire EEPROM.
// Holds the FSM state enum, opcodes and extended (opcode 00) sub-codes.
package jt93cxx_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        READ,
        DATA,
        ARMED,
        PROG,
        WAIT
    } state_t;

    localparam logic [1:0] OP_READ  = 2'b10;
    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_ERASE = 2'b11;
    localparam logic [1:0] OP_EXT   = 2'b00;

    // Sub-codes carried in the two address MSBs when opcode is OP_EXT
    localparam logic [1:0] EXT_EWEN = 2'b11;
    localparam logic [1:0] EXT_EWDS = 2'b00;
    localparam logic [1:0] EXT_ERAL = 2'b10;
    localparam logic [1:0] EXT_WRAL = 2'b01;

endpackage

// File: rtl/jt93cxx_if.sv
// Bus bundle for jt93cxx: Microwire serial pins plus the NVRAM dump port.
// master = CPU / frame side, slave = EEPROM.
interface jt93cxx_if #(
    parameter int DW = 16,
    parameter int AW = 6
);
    localparam int DMPW = AW + ((DW == 16) ? 1 : 0);

    logic            sclk;
    logic            sdi;
    logic            sdo;
    logic            scs;
    logic [DMPW-1:0] dump_addr;
    logic            dump_we;
    logic [7:0]      dump_dout;
    logic [7:0]      dump_din;
    logic            dump_clr;
    logic            dump_flag;

    modport master (
        output sclk, sdi, scs, dump_addr, dump_we, dump_dout, dump_clr,
        input  sdo, dump_din, dump_flag
    );

    modport slave (
        input  sclk, sdi, scs, dump_addr, dump_we, dump_dout, dump_clr,
        output sdo, dump_din, dump_flag
    );

endinterface

// File: rtl/jt93cxx_dpram.sv
// Single-clock true dual-port RAM, DW x 2^AW, registered read outputs.
// Ports: a = serial/program side (wins collisions), b = dump side.
module jt93cxx_dpram #(
    parameter int DW = 16,
    parameter int AW = 6
) (
    input  logic          clk,
    input  logic          i_we_a,
    input  logic [AW-1:0] i_addr_a,
    input  logic [DW-1:0] i_din_a,
    output logic [DW-1:0] o_q_a,
    input  logic          i_we_b,
    input  logic [AW-1:0] i_addr_b,
    input  logic [DW-1:0] i_din_b,
    output logic [DW-1:0] o_q_b
);
    logic [DW-1:0] r_mem [0:(1<<AW)-1];

    logic w_we_b;
    assign w_we_b = i_we_b & ~(i_we_a & (i_addr_a == i_addr_b));

    always_ff @(posedge clk) begin
        if (w_we_b) r_mem[i_addr_b] <= i_din_b;
        if (i_we_a) r_mem[i_addr_a] <= i_din_a;
        o_q_a <= r_mem[i_addr_a];
        o_q_b <= r_mem[i_addr_b];
    end

endmodule

// File: rtl/jt93cxx.sv
// 93Cxx Microwire EEPROM emulation with self-timed programming and dump port.
// Ports: clk, rst (sync, active high), bus (jt93cxx_if.slave).
module jt93cxx
    import jt93cxx_pkg::*;
#(
    parameter int DW       = 16,
    parameter int AW       = 6,
    parameter int BUSY_CYC = 64
) (
    input logic      clk,
    input logic      rst,
    jt93cxx_if.slave bus
);
    localparam int DMPW = AW + ((DW == 16) ? 1 : 0);
    localparam logic [4:0]    CMD_LAST = 5'(AW + 1);
    localparam logic [4:0]    DAT_LAST = 5'(DW - 1);
    localparam logic [15:0]   BC_LAST  = 16'(BUSY_CYC - 1);
    localparam logic [AW-1:0] A_LAST   = {AW{1'b1}};
    localparam logic [DW-1:0] MSB_MASK = {1'b1, {(DW-1){1'b0}}};

    state_t        r_st, w_st_n;
    logic          r_sclk_l;
    logic [4:0]    r_cnt, w_cnt_n;
    logic [AW:0]   r_sr, w_sr_n;
    logic [AW-1:0] r_addr, w_addr_n;
    logic [DW-1:0] r_data, w_data_n;
    logic          r_prog_en, w_prog_en_n;
    logic          r_all, w_all_n;
    logic          r_ph, w_ph_n;
    logic [15:0]   r_bc, w_bc_n;
    logic          r_sdo, w_sdo_n;
    logic          r_flag, w_flag_n;

    logic          w_rise, w_we_a, w_rbit;
    logic [AW+1:0] w_cmd;
    logic [DW-1:0] w_qa, w_qb, w_bdin;
    logic [AW-1:0] w_baddr;
    logic          w_bwe;

    assign w_rise = bus.sclk & ~r_sclk_l;
    assign w_cmd  = {r_sr, bus.sdi};
    assign w_rbit = |(w_qa & (MSB_MASK >> r_cnt));

    always_ff @(posedge clk) begin
        r_sclk_l <= bus.sclk;
        r_cnt    <= w_cnt_n;
        r_sr     <= w_sr_n;
        r_addr   <= w_addr_n;
        r_data   <= w_data_n;
        r_all    <= w_all_n;
        if (rst) begin
            r_st      <= IDLE;
            r_prog_en <= 1'b0;
            r_ph      <= 1'b0;
            r_bc      <= '0;
            r_sdo     <= 1'b1;
            r_flag    <= 1'b0;
        end else begin
            r_st      <= w_st_n;
            r_prog_en <= w_prog_en_n;
            r_ph      <= w_ph_n;
            r_bc      <= w_bc_n;
            r_sdo     <= w_sdo_n;
            r_flag    <= w_flag_n;
        end
    end

    always_comb begin
        w_st_n      = r_st;
        w_cnt_n     = r_cnt;
        w_sr_n      = r_sr;
        w_addr_n    = r_addr;
        w_data_n    = r_data;
        w_prog_en_n = r_prog_en;
        w_all_n     = r_all;
        w_ph_n      = r_ph;
        w_bc_n      = r_bc;
        w_sdo_n     = r_sdo;
        w_we_a      = 1'b0;
        unique case (r_st)
            IDLE: begin
                w_sdo_n = 1'b1;
                if (bus.scs && w_rise && bus.sdi) begin
                    w_st_n  = CMD;
                    w_cnt_n = '0;
                end
            end
            CMD: begin
                if (!bus.scs) begin
                    w_st_n = IDLE;
                end else if (w_rise) begin
                    w_sr_n  = w_cmd[AW:0];
                    w_cnt_n = r_cnt + 5'd1;
                    if (r_cnt == CMD_LAST) begin
                        w_cnt_n  = '0;
                        w_addr_n = w_cmd[AW-1:0];
                        w_all_n  = 1'b0;
                        case (w_cmd[AW+1:AW])
                            OP_READ: begin
                                w_st_n  = READ;
                                w_sdo_n = 1'b0;
                            end
                            OP_WRITE: w_st_n = DATA;
                            OP_ERASE: begin
                                w_st_n   = ARMED;
                                w_data_n = '1;
                            end
                            default: begin
                                case (w_cmd[AW-1:AW-2])
                                    EXT_EWEN: begin
                                        w_prog_en_n = 1'b1;
                                        w_st_n      = WAIT;
                                    end
                                    EXT_EWDS: begin
                                        w_prog_en_n = 1'b0;
                                        w_st_n      = WAIT;
                                    end
                                    EXT_ERAL: begin
                                        w_all_n  = 1'b1;
                                        w_data_n = '1;
                                        w_st_n   = ARMED;
                                    end
                                    default: begin
                                        w_all_n = 1'b1;
                                        w_st_n  = DATA;
                                    end
                                endcase
                            end
                        endcase
                    end
                end
            end
            READ: begin
                if (!bus.scs) begin
                    w_st_n  = IDLE;
                    w_sdo_n = 1'b1;
                end else if (w_rise) begin
                    w_sdo_n = w_rbit;
                    w_cnt_n = r_cnt + 5'd1;
                    if (r_cnt == DAT_LAST) begin
                        // next word is fetched while the host clocks low
                        w_cnt_n  = '0;
                        w_addr_n = r_addr + 1'b1;
                    end
                end
            end
            DATA: begin
                if (!bus.scs) begin
                    w_st_n = IDLE;
                end else if (w_rise) begin
                    w_data_n = {r_data[DW-2:0], bus.sdi};
                    w_cnt_n  = r_cnt + 5'd1;
                    if (r_cnt == DAT_LAST) begin
                        w_cnt_n = '0;
                        w_st_n  = r_prog_en ? ARMED : WAIT;
                    end
                end
            end
            ARMED: begin
                if (!bus.scs) begin
                    w_st_n = IDLE;
                    if (r_prog_en) begin
                        w_st_n = PROG;
                        w_ph_n = 1'b0;
                        w_bc_n = '0;
                        if (r_all) w_addr_n = '0;
                    end
                end
            end
            PROG: begin
                if (!r_ph) begin
                    w_we_a = 1'b1;
                    if (!r_all || r_addr == A_LAST) w_ph_n = 1'b1;
                    else w_addr_n = r_addr + 1'b1;
                end else begin
                    w_bc_n = r_bc + 16'd1;
                    if (r_bc == BC_LAST) begin
                        w_st_n  = IDLE;
                        w_sdo_n = 1'b1;
                    end
                end
            end
            WAIT: begin
                if (!bus.scs) w_st_n = IDLE;
            end
            default: w_st_n = IDLE;
        endcase
    end

    // clearing beats a same-cycle array write
    assign w_flag_n = bus.dump_clr ? 1'b0 : (w_we_a | r_flag);

    assign bus.sdo       = r_sdo & ~((r_st == PROG) & bus.scs);
    assign bus.dump_flag = r_flag;

    generate
        if (DW == 16) begin : g_x16
            logic [7:0] r_lo;
            logic       r_bsel;
            always_ff @(posedge clk) begin
                if (bus.dump_we && !bus.dump_addr[0]) r_lo <= bus.dump_dout;
                r_bsel <= bus.dump_addr[0];
            end
            assign w_baddr      = bus.dump_addr[DMPW-1:1];
            assign w_bwe        = bus.dump_we & bus.dump_addr[0];
            assign w_bdin       = {bus.dump_dout, r_lo};
            assign bus.dump_din = r_bsel ? w_qb[15:8] : w_qb[7:0];
        end else begin : g_x8
            assign w_baddr      = bus.dump_addr[DMPW-1:0];
            assign w_bwe        = bus.dump_we;
            assign w_bdin       = bus.dump_dout;
            assign bus.dump_din = w_qb;
        end
    endgenerate

    jt93cxx_dpram #(.DW(DW), .AW(AW)) u_ram (
        .clk      (clk),
        .i_we_a   (w_we_a),
        .i_addr_a (r_addr),
        .i_din_a  (r_data),
        .o_q_a    (w_qa),
        .i_we_b   (w_bwe),
        .i_addr_b (w_baddr),
        .i_din_b  (w_bdin),
        .o_q_b    (w_qb)
    );

endmodule

// File: tb/tb_jt93cxx.sv
// Scoreboard bench for jt93cxx: x16/AW=6 and x8/AW=7 instances.
// Expected values come from a word-array model of the EEPROM.
module tb_jt93cxx;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic       sclk = 1'b0, sdi = 1'b0, scs = 1'b0, sel8 = 1'b0;
    logic [6:0] daddr = '0;
    logic [7:0] ddout = '0;
    logic       dwe = 1'b0, dclr = 1'b0;
    logic       w_sdo, w_flag;
    logic [7:0] w_ddin;

    jt93cxx_if #(.DW(16), .AW(6)) b16 ();
    jt93cxx_if #(.DW(8),  .AW(7)) b8 ();

    assign b16.sclk      = sclk;
    assign b16.sdi       = sdi;
    assign b16.scs       = scs & ~sel8;
    assign b16.dump_addr = daddr;
    assign b16.dump_we   = dwe & ~sel8;
    assign b16.dump_dout = ddout;
    assign b16.dump_clr  = dclr & ~sel8;
    assign b8.sclk       = sclk;
    assign b8.sdi        = sdi;
    assign b8.scs        = scs & sel8;
    assign b8.dump_addr  = daddr;
    assign b8.dump_we    = dwe & sel8;
    assign b8.dump_dout  = ddout;
    assign b8.dump_clr   = dclr & sel8;
    assign w_sdo  = sel8 ? b8.sdo : b16.sdo;
    assign w_flag = sel8 ? b8.dump_flag : b16.dump_flag;
    assign w_ddin = sel8 ? b8.dump_din : b16.dump_din;

    jt93cxx #(.DW(16), .AW(6), .BUSY_CYC(64)) u16 (
        .clk(clk), .rst(rst), .bus(b16));
    jt93cxx #(.DW(8), .AW(7), .BUSY_CYC(64)) u8 (
        .clk(clk), .rst(rst), .bus(b8));

    // reference model, index 0 = x16 part, 1 = x8 part
    int unsigned mem [2][128];
    bit          pe [2];
    bit          flagm [2];
    int unsigned lo_m [2];

    typedef struct {
        string       name;
        int unsigned v;
    } item_t;
    item_t expq[$];
    item_t actq[$];
    int nvec = 0;
    int nerr = 0;

    initial begin
        item_t a, e;
        forever begin
            @(negedge clk);
            while (actq.size() > 0) begin
                a = actq.pop_front();
                nvec++;
                if (expq.size() == 0) begin
                    nerr++;
                    $display("FAIL %s: got %0h, nothing expected", a.name, a.v);
                end else begin
                    e = expq.pop_front();
                    if (e.v !== a.v || e.name != a.name) begin
                        nerr++;
                        $display("FAIL %s: got %0h, want %0h (%s)",
                                 a.name, a.v, e.v, e.name);
                    end
                end
            end
        end
    end

    function automatic int si(); return sel8 ? 1 : 0; endfunction
    function automatic int aw(); return sel8 ? 7 : 6; endfunction
    function automatic int dw(); return sel8 ? 8 : 16; endfunction
    function automatic int unsigned ones(); return sel8 ? 32'hFF : 32'hFFFF; endfunction

    task automatic expect_(string n, int unsigned v);
        item_t it;
        it.name = n; it.v = v;
        expq.push_back(it);
    endtask

    task automatic observe(string n, int unsigned v);
        item_t it;
        it.name = n; it.v = v;
        actq.push_back(it);
    endtask

    task automatic tick(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic bit_(logic b);
        sdi = b; sclk = 1'b0; tick(3);
        sclk = 1'b1; tick(3);
    endtask

    task automatic send(int unsigned v, int n);
        for (int i = n - 1; i >= 0; i--) bit_(v[i]);
    endtask

    task automatic cmd(int unsigned op, int unsigned addr);
        scs = 1'b1; tick(1);
        send(1, 1); send(op, 2); send(addr, aw());
    endtask

    // count low-sdo cycles with scs re-raised; bounded
    task automatic poll(output int z);
        z = 0;
        for (int i = 0; i < 5000; i++) begin
            @(negedge clk);
            if (w_sdo !== 1'b0) break;
            z++;
        end
        #1 scs = 1'b0; tick(2);
    endtask

    task automatic endcmd(output int z);
        scs = 1'b0; tick(1);
        scs = 1'b1;
        poll(z);
    endtask

    task automatic ext(string n, int unsigned code, bit has_data,
                       int unsigned d);
        int z;
        bit prog;
        prog = (code == 2 || code == 1) && pe[si()];
        expect_(n, prog ? (1 << aw()) + 64 : 0);
        cmd(0, code << (aw() - 2));
        if (has_data) send(d, dw());
        endcmd(z);
        observe(n, z);
        if (code == 3) pe[si()] = 1;
        if (code == 0) pe[si()] = 0;
        if (prog) begin
            flagm[si()] = 1;
            for (int i = 0; i < (1 << aw()); i++)
                mem[si()][i] = (code == 2) ? ones() : d;
        end
    endtask

    task automatic wr(int unsigned a, int unsigned d, bit erase);
        int z;
        expect_(erase ? "erase_busy" : "write_busy", pe[si()] ? 65 : 0);
        cmd(erase ? 3 : 1, a);
        if (!erase) send(d, dw());
        endcmd(z);
        observe(erase ? "erase_busy" : "write_busy", z);
        if (pe[si()]) begin
            mem[si()][a] = erase ? ones() : d;
            flagm[si()] = 1;
        end
    endtask

    task automatic rd(int unsigned a, int n);
        int unsigned w;
        expect_("read_dummy", 0);
        for (int k = 0; k < n; k++)
            expect_("read_word", mem[si()][(a + k) % (1 << aw())]);
        cmd(2, a);
        observe("read_dummy", w_sdo);
        for (int k = 0; k < n; k++) begin
            w = 0;
            for (int b = 0; b < dw(); b++) begin
                bit_(1'b0);
                w = (w << 1) | w_sdo;
            end
            observe("read_word", w);
        end
        scs = 1'b0; tick(2);
    endtask

    task automatic dwr(int unsigned a, int unsigned b);
        daddr = a[6:0]; ddout = b[7:0]; dwe = 1'b1; tick(1);
        dwe = 1'b0;
        if (sel8) mem[1][a] = b;
        else if (a % 2 == 0) lo_m[0] = b;
        else mem[0][a / 2] = (b << 8) | lo_m[0];
    endtask

    task automatic drd(int unsigned a);
        expect_("dump_rd", sel8 ? mem[1][a]
                : (mem[0][a / 2] >> (8 * (a % 2))) & 8'hFF);
        daddr = a[6:0]; tick(1);
        observe("dump_rd", w_ddin);
    endtask

    task automatic chkflag(string n);
        expect_(n, flagm[si()]);
        observe(n, w_flag);
    endtask

    initial begin
        int z;
        int unsigned a;
        tick(3);
        rst = 1'b0; tick(2);
        for (int s = 0; s < 2; s++) begin
            sel8 = (s == 1);
            expect_("reset_sdo", 1); observe("reset_sdo", w_sdo);
            chkflag("reset_flag");
            // load all-ones image, as a fresh part would hold
            for (int i = 0; i < 128; i++) dwr(i, 8'hFF);
        end

        sel8 = 1'b0;
        rd(5, 2);
        ext("ewen", 3, 0, 0);
        wr(5, 16'h1234, 0);
        rd(5, 1);
        drd(8'h0A);
        drd(8'h0B);
        chkflag("flag_set");

        dclr = 1'b1; tick(1); dclr = 1'b0;
        flagm[0] = 0;
        ext("ewds", 0, 0, 0);
        wr(5, 16'hABCD, 0);
        rd(5, 1);
        chkflag("flag_clr");

        ext("ewen", 3, 0, 0);
        ext("wral", 1, 1, 16'h5A5A);
        rd(6'h3F, 2);
        wr(6'h10, 0, 1);
        rd(6'h10, 1);

        // abort mid-DATA after 9 bits
        cmd(1, 6'h20);
        send(16'h1234 >> 7, 9);
        scs = 1'b0; tick(2);
        expect_("abort_sdo", 1); observe("abort_sdo", w_sdo);
        rd(6'h20, 1);

        // reset in the middle of an ERAL sweep
        cmd(0, 2 << 4);
        scs = 1'b0; tick(1);
        scs = 1'b1; tick(10);
        rst = 1'b1; tick(1); rst = 1'b0;
        expect_("rst_sdo", 1); observe("rst_sdo", w_sdo);
        scs = 1'b0; tick(2);
        pe[0] = 0; flagm[0] = 0;
        mem[0][0] = 16'hFFFF;
        chkflag("rst_flag");
        rd(0, 1);
        rd(6'h30, 1);
        wr(6'h30, 16'h1111, 0);
        rd(6'h30, 1);
        ext("ewen", 3, 0, 0);
        ext("eral", 2, 0, 0);

        repeat (16) begin
            a = $urandom_range(0, 63);
            if ($urandom_range(0, 1) == 1) wr(a, $urandom_range(0, 16'hFFFF), 0);
            else rd(a, 1 + $urandom_range(0, 1));
            if ($urandom_range(0, 2) == 0) drd($urandom_range(0, 127));
        end

        sel8 = 1'b1;
        dwr(7'h7F, 8'hC3);
        rd(7'h7F, 1);
        ext("ewen8", 3, 0, 0);
        // serial program write and dump write land on the same cycle;
        // one busy cycle elapses before polling starts
        expect_("collide_busy", 64);
        cmd(1, 7'h7F);
        send(8'h5E, 8);
        scs = 1'b0; tick(1);
        scs = 1'b1;
        daddr = 7'h7F; ddout = 8'h11; dwe = 1'b1; tick(1); dwe = 1'b0;
        poll(z);
        observe("collide_busy", z);
        mem[1][7'h7F] = 8'h5E; flagm[1] = 1;
        rd(7'h7F, 1);
        drd(7'h7F);
        repeat (8) begin
            a = $urandom_range(0, 127);
            if ($urandom_range(0, 1) == 1) wr(a, $urandom_range(0, 255), 0);
            else rd(a, 2);
        end
        chkflag("flag8");

        tick(4);
        if (expq.size() != 0) begin
            nerr += expq.size();
            $display("FAIL scoreboard: %0d responses never seen", expq.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
